fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Pipeline control block that sequences the instruction-fetch stage and its downstream pipeline registers. It merges the ID data-hazard request, the EXE branch resolution and the MEM-stage memory stall into one consistent set of signals:
- freeze controls for the PC register and the pipeline registers,
- flush controls for IF/ID and ID/EXE,
- the PC-mux redirect (`branchTakenOut`, `branchAddr`).

A branch that resolves during a memory stall is captured and replayed after the stall ends. The block sits between the hazard unit, the EXE stage, the MEM-stage SRAM interface and the IF stage.

## Interface
Parameters:
- `BOOT_CYCLES`, default 2: cycles the pipeline stays frozen after reset is released. Legal range is ≥1.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `hazard`  in  1  ID-stage data hazard (level).
- `branchTaken`  in  1  EXE-stage taken branch (level, held while EXE is frozen).
- `branchAddrIn`  in  32  EXE branch target.
- `memStall`  in  1  MEM-stage memory busy (level); whole pipeline must hold.
- `freezeIf`  out  1  freeze for the PC register and IF/ID (the PC loads when this is low).
- `freezePipe`  out  1  freeze for ID/EXE, EXE/MEM and MEM/WB.
- `flushIfId`  out  1  clear IF/ID.
- `flushIdExe`  out  1  clear ID/EXE (inserts a bubble).
- `branchTakenOut`  out  1  PC-mux select.
- `branchAddr`  out  32  PC-mux target.
- `state`  out  2  current FSM state, for debug.
- `stallCount`  out  `CNT_W`  stall-cycle counter.
- `flushCount`  out  `CNT_W`  redirect counter.

## Operation
The FSM has four states: BOOT=0, RUN=1, MEMWAIT=2, REPLAY=3. All outputs are combinational from the state, the inputs and the pending register.

Pending register:
- `pend` (1 bit) plus `pendAddr` (32 bits).
- Set on any edge where `memStall`=1 and `branchTaken`=1 and `pend`=0, in RUN or MEMWAIT; `pendAddr` takes `branchAddrIn`.
- Cleared on leaving REPLAY, and on reset.

BOOT:
- Outputs: `freezeIf`=1, `freezePipe`=1; flushes, `branchTakenOut` and `branchAddr` are all 0.
- A down-counter is loaded with `BOOT_CYCLES`-1 on reset.
- Go to RUN when the counter is 0; otherwise decrement.
- Inputs are ignored.

RUN, evaluated in priority order:
1. `memStall`=1: outputs are as in MEMWAIT; next state is MEMWAIT.
2. `branchTaken`=1: `branchTakenOut`=1, `branchAddr`=`branchAddrIn`, `flushIfId`=1, `flushIdExe`=1, `freezeIf`=0. `hazard` is ignored. Stay in RUN.
3. `hazard`=1: `freezeIf`=1, `flushIdExe`=1, `freezePipe`=0. Stay in RUN.
4. Otherwise all outputs are 0 and the block stays in RUN.

MEMWAIT:
- Outputs: `freezeIf`=1, `freezePipe`=1, no flush, `branchTakenOut`=0.
- `memStall`=0: next state is REPLAY if `pend`=1, else RUN.

REPLAY:
- Outputs: `branchTakenOut`=1, `branchAddr`=`pendAddr`, `flushIfId`=1, `flushIdExe`=1, `freezeIf`=0, `freezePipe`=0.
- The live `branchTaken` input is ignored in this cycle, because it comes from the same instruction.
- `memStall`=1 in REPLAY: the redirect still completes; next state is MEMWAIT and `pend` is cleared.
- Otherwise next state is RUN.

`branchAddr` is 0 whenever `branchTakenOut`=0.

Reset:
- `rst` has priority in every state, including mid-stall and mid-REPLAY.
- Next state is BOOT; `pend`=0, `pendAddr`=0, counters are 0.
- While `rst`=1, the outputs are the BOOT values and `state`=0.

## Timing
- Hazard and branch responses have zero-cycle latency: they are combinational in the same cycle as the input. The PC takes the target at the next edge.
- A stall or branch entry into MEMWAIT is registered: MEMWAIT outputs are driven combinationally in the entry cycle, and the state register holds from the next edge.
- Exit from MEMWAIT takes one cycle: the first cycle with `memStall`=0 is spent in MEMWAIT with freezes still high, then RUN or REPLAY follows.
- REPLAY always lasts exactly one cycle.
- BOOT lasts exactly `BOOT_CYCLES` cycles after the first edge with `rst`=0.

## Configuration
Macro `FETCH_CTRL_PERF_EN`.

Defined:
- `stallCount` increments on each cycle outside BOOT in which `freezeIf`=1.
- `flushCount` increments on each cycle in which `branchTakenOut`=1.
- Both counters saturate at all-ones and clear on `rst`.

Undefined:
- Both counter outputs are constant 0.
- No counter flops are built.
- Ports remain present.

## Test plan
- Reset and boot: `rst` high for 2 cycles, then low with `BOOT_CYCLES`=2. Required: `state`=0 with both freezes at 1 for exactly 2 cycles, then `state`=1 with all outputs 0.
- Hazard: `hazard` high for 3 cycles in RUN. Required: `freezeIf`=1 and `flushIdExe`=1 for those 3 cycles, `freezePipe`=0; with the macro defined, `stallCount` reaches 3.
- Branch against hazard: `branchTaken`=1, `branchAddrIn`=0x40, `hazard`=1 in the same cycle. Required: in that cycle `branchTakenOut`=1, `branchAddr`=0x40, both flushes at 1 and `freezeIf`=0.
- Branch under stall: `memStall` high for 4 cycles with `branchTaken` high and `branchAddrIn`=0x100. Required: no redirect while stalled; one MEMWAIT cycle after `memStall` falls; then one REPLAY cycle with `branchAddr`=0x100 and both flushes at 1; then RUN. `flushCount` increments by exactly 1.
- Reset during MEMWAIT with `pend`=1. Required: the next state is BOOT, there is no REPLAY afterwards, and the counters are 0.
- Counter saturation with `CNT_W`=4 and the macro defined: 20 hazard cycles. Required: `stallCount` holds at 15.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencing and pipeline freeze/flush control.
// Merges the ID hazard, the EXE branch resolution and the MEM stall into one
// set of freeze, flush and PC-redirect signals. A branch that resolves while
// memory is stalled is captured and replayed once the stall has drained.
//
// Optional feature: define FETCH_CTRL_PERF_EN to build the saturating
// stall/redirect counters; otherwise both counter outputs are tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// BOOT    | post-reset hold, whole pipeline frozen for BOOT_CYCLES
// RUN     | normal operation, hazard/branch resolved combinationally
// MEMWAIT | memory stall in progress (plus one drain cycle on exit)
// REPLAY  | one-cycle redirect to the branch captured during the stall
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branchTaken,
  input  logic [31:0]      branchAddrIn,
  input  logic             memStall,
  output logic             freezeIf,
  output logic             freezePipe,
  output logic             flushIfId,
  output logic             flushIdExe,
  output logic             branchTakenOut,
  output logic [31:0]      branchAddr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LOAD = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_REPLAY  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_addr_q, pend_addr_d;

  // State, boot timer and pending-branch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= BOOT_LOAD;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Next-state, boot countdown and branch capture during memory stalls.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == '0) state_d = ST_RUN;
        else                  boot_cnt_d = boot_cnt_q - 1'b1;
      end
      ST_RUN: begin
        if (memStall) state_d = ST_MEMWAIT;
      end
      ST_MEMWAIT: begin
        if (!memStall) state_d = pend_q ? ST_REPLAY : ST_RUN;
      end
      ST_REPLAY: begin
        // The replayed redirect always completes; a new stall just re-enters
        // MEMWAIT with nothing pending.
        pend_d  = 1'b0;
        state_d = memStall ? ST_MEMWAIT : ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
    if ((state_q == ST_RUN || state_q == ST_MEMWAIT) &&
        memStall && branchTaken && !pend_q) begin
      pend_d      = 1'b1;
      pend_addr_d = branchAddrIn;
    end
  end

  // Freeze/flush/redirect outputs; reset forces the BOOT values.
  always_comb begin
    freezeIf       = 1'b0;
    freezePipe     = 1'b0;
    flushIfId      = 1'b0;
    flushIdExe     = 1'b0;
    branchTakenOut = 1'b0;
    branchAddr     = 32'd0;
    case (state_q)
      ST_BOOT: begin
        freezeIf   = 1'b1;
        freezePipe = 1'b1;
      end
      ST_RUN: begin
        if (memStall) begin
          freezeIf   = 1'b1;
          freezePipe = 1'b1;
        end else if (branchTaken) begin
          branchTakenOut = 1'b1;
          branchAddr     = branchAddrIn;
          flushIfId      = 1'b1;
          flushIdExe     = 1'b1;
        end else if (hazard) begin
          freezeIf   = 1'b1;
          flushIdExe = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        freezeIf   = 1'b1;
        freezePipe = 1'b1;
      end
      ST_REPLAY: begin
        // Live branchTaken belongs to the instruction being replayed.
        branchTakenOut = 1'b1;
        branchAddr     = pend_addr_q;
        flushIfId      = 1'b1;
        flushIdExe     = 1'b1;
      end
      default: begin
        freezeIf   = 1'b1;
        freezePipe = 1'b1;
      end
    endcase
    if (rst) begin
      freezeIf       = 1'b1;
      freezePipe     = 1'b1;
      flushIfId      = 1'b0;
      flushIdExe     = 1'b0;
      branchTakenOut = 1'b0;
      branchAddr     = 32'd0;
    end
  end

  assign state = rst ? 2'd0 : state_q;

`ifdef FETCH_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments: freeze cycles outside BOOT, and redirect cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != ST_BOOT && freezeIf && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (branchTakenOut && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors with hand-computed expected outputs,
// queued by the driver and checked by an independent monitor.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddrIn = 32'd0;
  logic        memStall = 1'b0;

  logic        freezeIf, freezePipe, flushIfId, flushIdExe, branchTakenOut;
  logic [31:0] branchAddr;
  logic [1:0]  state;
  logic [15:0] stallCount, flushCount;

  logic        f4_fi, f4_fp, f4_fif, f4_fie, f4_bto;
  logic [31:0] f4_addr;
  logic [1:0]  f4_state;
  logic [3:0]  f4_sc, f4_fc;

  fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branchTaken(branchTaken),
    .branchAddrIn(branchAddrIn), .memStall(memStall),
    .freezeIf(freezeIf), .freezePipe(freezePipe), .flushIfId(flushIfId),
    .flushIdExe(flushIdExe), .branchTakenOut(branchTakenOut),
    .branchAddr(branchAddr), .state(state),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hazard(hazard), .branchTaken(branchTaken),
    .branchAddrIn(branchAddrIn), .memStall(memStall),
    .freezeIf(f4_fi), .freezePipe(f4_fp), .flushIfId(f4_fif),
    .flushIdExe(f4_fie), .branchTakenOut(f4_bto),
    .branchAddr(f4_addr), .state(f4_state),
    .stallCount(f4_sc), .flushCount(f4_fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic        fi, fp, fif, fie, bto;
    logic [31:0] addr;
    logic [15:0] sc16, fc16;
    logic [3:0]  sc4, fc4;
    bit          cnt_chk;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  int m_sc16 = 0, m_fc16 = 0, m_sc4 = 0, m_fc4 = 0;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", {30'd0, state}, {30'd0, e.st});
        chk("freezeIf", {31'd0, freezeIf}, {31'd0, e.fi});
        chk("freezePipe", {31'd0, freezePipe}, {31'd0, e.fp});
        chk("flushIfId", {31'd0, flushIfId}, {31'd0, e.fif});
        chk("flushIdExe", {31'd0, flushIdExe}, {31'd0, e.fie});
        chk("branchTakenOut", {31'd0, branchTakenOut}, {31'd0, e.bto});
        chk("branchAddr", branchAddr, e.addr);
        chk("dut4_outs", {25'd0, f4_state, f4_fi, f4_fp, f4_fif, f4_fie, f4_bto},
            {25'd0, e.st, e.fi, e.fp, e.fif, e.fie, e.bto});
        chk("dut4_branchAddr", f4_addr, e.addr);
        if (e.cnt_chk) begin
          chk("stallCount", {16'd0, stallCount}, {16'd0, e.sc16});
          chk("flushCount", {16'd0, flushCount}, {16'd0, e.fc16});
          chk("stallCount_w4", {28'd0, f4_sc}, {28'd0, e.sc4});
          chk("flushCount_w4", {28'd0, f4_fc}, {28'd0, e.fc4});
        end
      end
    end
  end

  // One cycle: drive inputs, queue the hand-computed expected outputs.
  task automatic v(input int r, input int h, input int b, input int a, input int m,
                   input int st, input int fi, input int fp, input int fif,
                   input int fie, input int bto, input int addr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r[0]; hazard = h[0]; branchTaken = b[0];
    branchAddrIn = a; memStall = m[0];
    e.st = st[1:0]; e.fi = fi[0]; e.fp = fp[0]; e.fif = fif[0];
    e.fie = fie[0]; e.bto = bto[0]; e.addr = addr;
`ifdef FETCH_CTRL_PERF_EN
    e.sc16 = m_sc16[15:0]; e.fc16 = m_fc16[15:0];
    e.sc4 = m_sc4[3:0]; e.fc4 = m_fc4[3:0];
    e.cnt_chk = m_valid;
`else
    e.sc16 = 16'd0; e.fc16 = 16'd0; e.sc4 = 4'd0; e.fc4 = 4'd0;
    e.cnt_chk = 1'b1;
`endif
    q.push_back(e);
    if (r != 0) begin
      m_sc16 = 0; m_fc16 = 0; m_sc4 = 0; m_fc4 = 0; m_valid = 1'b1;
    end else begin
      if (st != 0 && fi != 0) begin
        if (m_sc16 < 65535) m_sc16++;
        if (m_sc4 < 15) m_sc4++;
      end
      if (bto != 0) begin
        if (m_fc16 < 65535) m_fc16++;
        if (m_fc4 < 15) m_fc4++;
      end
    end
  endtask

  // Watchdog so the run always ends with a summary.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected normal completion");
    n_total++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    // reset 2 cycles, then BOOT for exactly 2 cycles, then RUN idle
    v(1,0,0,0,0, 0,1,1,0,0,0,0);
    v(1,0,0,0,0, 0,1,1,0,0,0,0);
    v(0,0,0,0,0, 0,1,1,0,0,0,0);
    v(0,1,1,'h55,1, 0,1,1,0,0,0,0);   // inputs ignored in BOOT
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    // hazard for 3 cycles
    for (int i = 0; i < 3; i++) v(0,1,0,0,0, 1,1,0,0,1,0,0);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    // branch beats hazard
    v(0,1,1,'h40,0, 1,0,0,1,1,1,'h40);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    // branch under a 4-cycle stall, then drain, replay, run
    v(0,0,1,'h100,1, 1,1,1,0,0,0,0);
    for (int i = 0; i < 3; i++) v(0,0,1,'h100,1, 2,1,1,0,0,0,0);
    v(0,0,1,'h100,0, 2,1,1,0,0,0,0);
    v(0,0,1,'h100,0, 3,0,0,1,1,1,'h100);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    // reset while in MEMWAIT with a pending branch: no replay afterwards
    v(0,0,1,'h200,1, 1,1,1,0,0,0,0);
    v(0,0,0,0,1, 2,1,1,0,0,0,0);
    v(1,0,0,0,1, 0,1,1,0,0,0,0);
    v(0,0,0,0,0, 0,1,1,0,0,0,0);
    v(0,0,0,0,0, 0,1,1,0,0,0,0);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    // 20 hazard cycles: the 4-bit stall counter saturates at 15
    for (int i = 0; i < 20; i++) v(0,1,0,0,0, 1,1,0,0,1,0,0);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    // stall hits during REPLAY: redirect completes, back to MEMWAIT, no second replay
    v(0,0,1,'h300,1, 1,1,1,0,0,0,0);
    v(0,0,1,'h300,0, 2,1,1,0,0,0,0);
    v(0,0,1,'h300,1, 3,0,0,1,1,1,'h300);
    v(0,0,0,0,1, 2,1,1,0,0,0,0);
    v(0,0,0,0,0, 2,1,1,0,0,0,0);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    v(0,0,0,0,0, 1,0,0,0,0,0,0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
